swi_debouncer: RTL and testbench



---
 rtl/swi_debouncer_pkg.sv | 15 +
 rtl/swi_debouncer_if.sv | 38 +++
 rtl/swi_debouncer_debounce_bit.sv | 70 +++++++
 rtl/swi_debouncer.sv | 55 +++++
 tb/tb_swi_debouncer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/swi_debouncer_pkg.sv
// ============================================================================
// Module : swi_debouncer_pkg
// Brief  : Board-level constants shared by the switch-conditioning slice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swi_debouncer_pkg;

   localparam int NBITS_TOP       = 8;
   localparam int DEBOUNCE_CYCLES = 3;

endpackage : swi_debouncer_pkg

`default_nettype wire

// File: rtl/swi_debouncer_if.sv
// ============================================================================
// Module : swi_debouncer_if
// Brief  : Raw switch levels in, debounced levels and edge strobes out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface swi_debouncer_if
   import swi_debouncer_pkg::*;
#(
   parameter int NBITS = NBITS_TOP
) ();

   logic [NBITS-1:0] swi_raw;
   logic [NBITS-1:0] swi_db;
   logic [NBITS-1:0] rise;
   logic [NBITS-1:0] fall;
   logic             changed;

   modport master (
      output swi_raw,
      input  swi_db,
      input  rise,
      input  fall,
      input  changed
   );

   modport slave (
      input  swi_raw,
      output swi_db,
      output rise,
      output fall,
      output changed
   );

endinterface : swi_debouncer_if

`default_nettype wire

// File: rtl/swi_debouncer_debounce_bit.sv
// ============================================================================
// Module : debounce_bit
// Brief  : One switch bit: 2-flop synchronizer, stability counter, edge strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit
   import swi_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  wire logic clk_2,
   input  wire logic reset,
   input  wire logic i_raw,
   output logic      o_db,
   output logic      o_rise,
   output logic      o_fall,
   output logic      o_accept
);

   localparam int              CNTW      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNTW-1:0] c_CNT_MAX = CNTW'(STABLE_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic [CNTW-1:0] r_cnt;
   logic            r_db;
   logic            r_rise;
   logic            r_fall;

   logic            w_diff;
   logic            w_accept;

   assign w_diff   = (r_sync2 != r_db);
   // The accepting sample is the STABLE_CYCLES-th consecutive disagreement.
   assign w_accept = w_diff && (r_cnt == c_CNT_MAX);

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_cnt   <= '0;
         r_db    <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_rise  <= w_accept &  r_sync2;
         r_fall  <= w_accept & ~r_sync2;
         if (!w_diff || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNTW'(1);
         end
         if (w_accept) begin
            r_db <= r_sync2;
         end
      end
   end

   assign o_db     = r_db;
   assign o_rise   = r_rise;
   assign o_fall   = r_fall;
   assign o_accept = w_accept;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/swi_debouncer.sv
// ============================================================================
// Module : swi_debouncer
// Brief  : Conditions NBITS raw switches into stable levels and edge strobes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swi_debouncer
   import swi_debouncer_pkg::*;
#(
   parameter int NBITS         = NBITS_TOP,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  wire logic       clk_2,
   input  wire logic       reset,
   swi_debouncer_if.slave  bus
);

   logic [NBITS-1:0] w_db;
   logic [NBITS-1:0] w_rise;
   logic [NBITS-1:0] w_fall;
   logic [NBITS-1:0] w_accept;
   logic             r_changed;

   for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
      debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_debounce_bit (
         .clk_2    (clk_2),
         .reset    (reset),
         .i_raw    (bus.swi_raw[gi]),
         .o_db     (w_db[gi]),
         .o_rise   (w_rise[gi]),
         .o_fall   (w_fall[gi]),
         .o_accept (w_accept[gi])
      );
   end

   // Registered from the per-bit accept terms so it lines up with rise/fall.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_accept;
      end
   end

   assign bus.swi_db  = w_db;
   assign bus.rise    = w_rise;
   assign bus.fall    = w_fall;
   assign bus.changed = r_changed;

endmodule : swi_debouncer

`default_nettype wire

// File: tb/tb_swi_debouncer.sv
// ============================================================================
// Module : tb_swi_debouncer
// Brief  : Directed vector bench for swi_debouncer (NBITS=8, STABLE_CYCLES=3).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swi_debouncer;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] db;
      logic [7:0] rise;
      logic [7:0] fall;
      logic       ch;
   } vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   vec_t vecs[$];

   swi_debouncer_if #(.NBITS(8)) sw_if ();

   swi_debouncer #(
      .NBITS         (8),
      .STABLE_CYCLES (3)
   ) dut (
      .clk_2 (clk),
      .reset (rst),
      .bus   (sw_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [7:0] raw, input logic [7:0] db,
                      input logic [7:0] rise, input logic [7:0] fall,
                      input logic ch);
      vec_t v;
      v.raw = raw; v.db = db; v.rise = rise; v.fall = fall; v.ch = ch;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] db,
                        input logic [7:0] rise, input logic [7:0] fall,
                        input logic ch);
      n_vec++;
      if (sw_if.swi_db !== db || sw_if.rise !== rise ||
          sw_if.fall !== fall || sw_if.changed !== ch) begin
         n_err++;
         $display("FAIL %s: got db=%h rise=%h fall=%h ch=%b, want db=%h rise=%h fall=%h ch=%b",
                  name, sw_if.swi_db, sw_if.rise, sw_if.fall, sw_if.changed,
                  db, rise, fall, ch);
      end
   endtask

   initial begin
      int         strobes;
      int         strobe_edge;
      logic [7:0] s_rise;
      logic [7:0] s_fall;
      logic       s_ch;

      n_vec = 0;
      n_err = 0;

      // Power-on edge, then debounce of switches held high at reset release.
      add(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
      add(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
      // All switches back to 0.
      add(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'hFF, 1'b1);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // Two-cycle glitch on bit 4 is rejected.
      add(8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // Exactly three cycles on bit 7 is accepted, then released.
      add(8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h80, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h80, 8'h80, 8'h00, 1'b1);
      add(8'h00, 8'h80, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h80, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h80, 1'b1);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // Reach 0x02, then simultaneous swap to 0x01.
      for (int i = 0; i < 4; i++) add(8'h02, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h02, 8'h02, 8'h02, 8'h00, 1'b1);
      add(8'h02, 8'h02, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) add(8'h01, 8'h02, 8'h00, 8'h00, 1'b0);
      add(8'h01, 8'h01, 8'h01, 8'h02, 1'b1);
      add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
      // Back to 0x00.
      for (int i = 0; i < 4; i++) add(8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      // Bounce 1,0,1,1,0 then a steady run of 1s: one rise, 4 edges into the run.
      add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) add(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
      add(8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
      add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
      add(8'h01, 8'h01, 8'h00, 8'h00, 1'b0);

      rst          = 1'b1;
      sw_if.swi_raw = 8'hFF;
      repeat (3) @(posedge clk);
      #1 check("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         sw_if.swi_raw = vecs[i].raw;
         @(posedge clk);
         #1 check($sformatf("vec[%0d]", i), vecs[i].db, vecs[i].rise,
                  vecs[i].fall, vecs[i].ch);
         @(negedge clk);
      end

      // Settle on 0x5A, then start a bit-0 count and cut it with async reset.
      sw_if.swi_raw = 8'h5A;
      repeat (6) @(posedge clk);
      #1 check("settle_5A", 8'h5A, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      sw_if.swi_raw = 8'h5B;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      sw_if.swi_raw = 8'h5A;
      rst           = 1'b0;

      strobes     = 0;
      strobe_edge = 0;
      s_rise      = 8'h00;
      s_fall      = 8'h00;
      s_ch        = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk);
         #1;
         if (sw_if.rise != 8'h00 || sw_if.fall != 8'h00 || sw_if.changed) begin
            strobes++;
            strobe_edge = e;
            s_rise      = sw_if.rise;
            s_fall      = sw_if.fall;
            s_ch        = sw_if.changed;
         end
      end
      n_vec++;
      if (strobes != 1 || strobe_edge != 5) begin
         n_err++;
         $display("FAIL post_reset_strobe_count: got %0d strobe cycles (last at edge %0d), want 1 at edge 5",
                  strobes, strobe_edge);
      end
      n_vec++;
      if (s_rise !== 8'h5A || s_fall !== 8'h00 || s_ch !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_strobe_value: got rise=%h fall=%h ch=%b, want rise=5a fall=00 ch=1",
                  s_rise, s_fall, s_ch);
      end
      check("post_reset_final", 8'h5A, 8'h00, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_swi_debouncer

`default_nettype wire
